cache_fill_arbiter: RTL



---
 rtl/cache_pkg.sv | 24 ++
 rtl/cache_fill_arbiter_fill_seq.sv | 46 ++++
 rtl/cache_fill_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared geometry, state type and address helper for the cache fill arbiter.
package cache_pkg;

  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int BLOCK_BYTES     = 16;
  localparam int WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);
  localparam int OFFSET_W        = $clog2(BLOCK_BYTES);
  localparam int CNT_W           = WORD_IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL_D,
    ST_FILL_I,
    ST_WRITE
  } fill_state_e;

  // Clears the byte offset so the result points at the first word of the block.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(BLOCK_BYTES - 1);
  endfunction

endpackage

// File: rtl/cache_fill_arbiter_fill_seq.sv
// Block refill sequencer: latches the block base, counts issued and received words,
// and generates in-block read addresses.
module fill_seq
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic [ADDR_W-1:0]     i_base_addr,
  input  logic                  i_issue_step,
  input  logic                  i_recv_step,
  output logic [ADDR_W-1:0]     o_issue_addr,
  output logic [WORD_IDX_W-1:0] o_recv_idx,
  output logic                  o_issue_done,
  output logic                  o_recv_done
);

  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [CNT_W-1:0]  r_recv_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else if (i_clear) begin
      r_base      <= block_base(i_base_addr);
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else begin
      if (i_issue_step && !o_issue_done)
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      if (i_recv_step && (r_recv_cnt != CNT_W'(WORDS_PER_BLOCK)))
        r_recv_cnt <= r_recv_cnt + CNT_W'(1);
    end
  end

  // The word offset is ORed into the zeroed offset bits, so the walk never carries out of the block.
  assign o_issue_addr = r_base | ADDR_W'({r_issue_cnt[WORD_IDX_W-1:0], 1'b0});
  assign o_recv_idx   = r_recv_cnt[WORD_IDX_W-1:0];
  assign o_issue_done = (r_issue_cnt == CNT_W'(WORDS_PER_BLOCK));
  // High while the word being received now is the last one of the block.
  assign o_recv_done  = (r_recv_cnt == CNT_W'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I-cache and D-cache misses plus write-through stores onto the single
// memory port, running 8-word block refills and single-word store writes.
module cache_fill_arbiter
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_miss,
  input  logic [ADDR_W-1:0]     i_miss_addr,
  input  logic                  d_miss,
  input  logic [ADDR_W-1:0]     d_miss_addr,
  input  logic                  d_write,
  input  logic [ADDR_W-1:0]     d_write_addr,
  input  logic [DATA_W-1:0]     d_write_data,
  output logic                  d_write_ack,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_data_out,
  input  logic [DATA_W-1:0]     mem_data_in,
  input  logic                  mem_data_valid,
  output logic [DATA_W-1:0]     fill_data,
  output logic [WORD_IDX_W-1:0] fill_word_idx,
  output logic                  fill_we_i,
  output logic                  fill_we_d,
  output logic                  tag_we_i,
  output logic                  tag_we_d,
  output logic                  i_fill_busy,
  output logic                  d_fill_busy
);

  fill_state_e r_state;
  fill_state_e w_next_state;

  logic                  w_seq_clear;
  logic                  w_issue_step;
  logic                  w_recv_step;
  logic [ADDR_W-1:0]     w_miss_addr;
  logic [ADDR_W-1:0]     w_issue_addr;
  logic [WORD_IDX_W-1:0] w_recv_idx;
  logic                  w_issue_done;
  logic                  w_recv_done;

  fill_seq u_fill_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_seq_clear),
    .i_base_addr  (w_miss_addr),
    .i_issue_step (w_issue_step),
    .i_recv_step  (w_recv_step),
    .o_issue_addr (w_issue_addr),
    .o_recv_idx   (w_recv_idx),
    .o_issue_done (w_issue_done),
    .o_recv_done  (w_recv_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // The D miss address wins the base latch because a D miss also wins arbitration.
  assign w_miss_addr = d_miss ? d_miss_addr : i_miss_addr;
  assign i_fill_busy = (r_state == ST_FILL_I);
  assign d_fill_busy = (r_state == ST_FILL_D);

  always_comb begin
    w_next_state  = r_state;
    w_seq_clear   = 1'b0;
    w_issue_step  = 1'b0;
    w_recv_step   = 1'b0;
    d_write_ack   = 1'b0;
    mem_enable    = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = '0;
    mem_data_out  = '0;
    fill_data     = '0;
    fill_word_idx = '0;
    fill_we_i     = 1'b0;
    fill_we_d     = 1'b0;
    tag_we_i      = 1'b0;
    tag_we_d      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_seq_clear = 1'b1;
        if (d_miss)       w_next_state = ST_FILL_D;
        else if (d_write) w_next_state = ST_WRITE;
        else if (i_miss)  w_next_state = ST_FILL_I;
      end

      ST_WRITE: begin
        mem_enable   = 1'b1;
        mem_wr       = 1'b1;
        mem_addr     = d_write_addr;
        mem_data_out = d_write_data;
        d_write_ack  = 1'b1;
        w_next_state = ST_IDLE;
      end

      ST_FILL_D, ST_FILL_I: begin
        if (!w_issue_done) begin
          mem_enable   = 1'b1;
          mem_addr     = w_issue_addr;
          w_issue_step = 1'b1;
        end
        // Returning words are written in arrival order; the last one also validates the tag.
        if (mem_data_valid) begin
          fill_data     = mem_data_in;
          fill_word_idx = w_recv_idx;
          fill_we_d     = (r_state == ST_FILL_D);
          fill_we_i     = (r_state == ST_FILL_I);
          w_recv_step   = 1'b1;
          if (w_recv_done) begin
            tag_we_d     = (r_state == ST_FILL_D);
            tag_we_i     = (r_state == ST_FILL_I);
            w_next_state = ST_IDLE;
          end
        end
      end

      default: w_next_state = ST_IDLE;
    endcase
  end

endmodule
